if_fetch_unit: RTL

Instruction-fetch stage of the 5-stage MIPS pipeline: owns the program counter, issues word reads to instruction memory over a request/response handshake, and presents each fetched instruction with its PC and PC+4 to the IF/ID pipeline register. It honours hazard-unit stalls through a one-entry skid buffer. It also accepts branch/jump redirects from later stages and discards the in-flight fetch when a redirect arrives.

---
 rtl/mips_pkg.sv | 13 +
 rtl/fetch_skid_buf.sv | 40 ++++
 rtl/if_fetch_unit.sv | 131 +++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline: fetch FSM states and fetch constants.
package mips_pkg;

  typedef enum logic {
    FETCH = 1'b0,
    WAIT  = 1'b1
  } fetch_state_t;

  localparam logic [31:0] INSTR_NOP        = 32'h0000_0000;
  localparam logic [31:0] PC_STEP          = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {instruction, pc} holding register that catches a fetched word
// while the IF/ID output slot is stalled.
module fetch_skid_buf
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load,
  input  logic        i_clear,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_pc,
  output logic        o_valid,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc
);

  logic        r_valid;
  logic [31:0] r_instr;
  logic [31:0] r_pc;

  // Clear wins over load so a redirect always empties the buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_instr <= INSTR_NOP;
      r_pc    <= 32'h0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_instr <= i_instr;
      r_pc    <= i_pc;
    end
  end

  assign o_valid = r_valid;
  assign o_instr = r_instr;
  assign o_pc    = r_pc;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC, single-outstanding imem request FSM, redirect
// discard tracking, and a registered IF/ID output slot backed by a skid buffer.
module if_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        out_valid,
  output logic [31:0] instruction_out,
  output logic [31:0] PCNow_out,
  output logic [31:0] PCNext4_out
);

  fetch_state_t r_state, w_stateNext;
  logic [31:0]  r_pc, w_pcNext;
  logic         r_discard, w_discardNext;

  logic         r_outValid;
  logic [31:0]  r_instr;
  logic [31:0]  r_pcNow;
  logic [31:0]  r_pcNext4;

  logic         w_bufValid;
  logic [31:0]  w_bufInstr;
  logic [31:0]  w_bufPc;

  logic         w_accept;
  logic         w_deliver;
  logic         w_consume;
  logic         w_bufLoad;
  logic         w_bufClear;

  assign imem_req   = ~rst & (r_state == FETCH) & ~w_bufValid;
  assign imem_addr  = r_pc;
  assign w_accept   = imem_req & imem_ready;
  assign w_deliver  = (r_state == WAIT) & imem_rvalid & ~r_discard & ~redirect_valid;
  assign w_consume  = r_outValid & ~stall;
  assign w_bufLoad  = w_deliver & r_outValid & ~w_consume;
  assign w_bufClear = redirect_valid | (w_consume & w_bufValid);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= FETCH;
      r_pc      <= RESET_PC;
      r_discard <= 1'b0;
    end else begin
      r_state   <= w_stateNext;
      r_pc      <= w_pcNext;
      r_discard <= w_discardNext;
    end
  end

  // A redirect landing in WAIT together with rvalid drops that word directly
  // rather than arming discard for a response that will never come.
  always_comb begin
    w_stateNext   = r_state;
    w_pcNext      = r_pc;
    w_discardNext = r_discard;
    case (r_state)
      FETCH: begin
        if (w_accept) w_stateNext = WAIT;
      end
      WAIT: begin
        if (imem_rvalid) begin
          w_stateNext   = FETCH;
          w_discardNext = 1'b0;
          if (!r_discard) w_pcNext = r_pc + PC_STEP;
        end
      end
      default: w_stateNext = FETCH;
    endcase
    if (redirect_valid) begin
      w_pcNext = redirect_pc & ~32'h3;
      if (w_accept || ((r_state == WAIT) && !imem_rvalid)) begin
        w_discardNext = 1'b1;
        w_stateNext   = WAIT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_outValid <= 1'b0;
      r_instr    <= INSTR_NOP;
      r_pcNow    <= 32'h0;
      r_pcNext4  <= 32'h0;
    end else if (redirect_valid) begin
      r_outValid <= 1'b0;
    end else if (w_deliver && (!r_outValid || w_consume)) begin
      r_outValid <= 1'b1;
      r_instr    <= imem_rdata;
      r_pcNow    <= r_pc;
      r_pcNext4  <= r_pc + PC_STEP;
    end else if (w_consume && w_bufValid) begin
      r_outValid <= 1'b1;
      r_instr    <= w_bufInstr;
      r_pcNow    <= w_bufPc;
      r_pcNext4  <= w_bufPc + PC_STEP;
    end else if (w_consume) begin
      r_outValid <= 1'b0;
    end
  end

  fetch_skid_buf u_skid (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_bufLoad),
    .i_clear (w_bufClear),
    .i_instr (imem_rdata),
    .i_pc    (r_pc),
    .o_valid (w_bufValid),
    .o_instr (w_bufInstr),
    .o_pc    (w_bufPc)
  );

  assign out_valid       = r_outValid;
  assign instruction_out = r_instr;
  assign PCNow_out       = r_pcNow;
  assign PCNext4_out     = r_pcNext4;

endmodule
